mips_hilo_muldiv: RTL and testbench

Iterative multiply/divide unit owning the HI/LO register pair for the MIPS core, replacing the single-cycle HI/LO path in the ALU. It executes MULT, MULTU, DIV and DIVU over a parametrised operand width, one bit per cycle, and services MTHI and MTLO writes. While an operation is in flight it raises `busy`, which the core uses to stall MFHI and MFLO and any further mul/div issue.

---
 rtl/mips_muldiv_pkg.sv | 36 +++
 rtl/mips_hilo_muldiv.sv | 100 ++++++++++
 tb/tb_mips_hilo_muldiv.sv | 115 +++++++++++
 3 files changed

// File: rtl/mips_muldiv_pkg.sv
// mips_muldiv_pkg: op/state encodings and shared datapath helpers for the HI/LO mul/div unit
package mips_muldiv_pkg;
  localparam int MAXW = 64;
  localparam logic [1:0] OP_MULT  = 2'd0;
  localparam logic [1:0] OP_MULTU = 2'd1;
  localparam logic [1:0] OP_DIV   = 2'd2;
  localparam logic [1:0] OP_DIVU  = 2'd3;
  typedef enum logic [1:0] {MULT = OP_MULT, MULTU = OP_MULTU, DIV = OP_DIV, DIVU = OP_DIVU} muldiv_op_t;
  typedef enum logic [1:0] {IDLE, RUN, SIGN} muldiv_state_t;
  typedef logic [2*MAXW-1:0] wide_t;
  function automatic wide_t neg(input wide_t x);
    return ~x + wide_t'(1);
  endfunction
  function automatic wide_t mag(input wide_t x, input logic s);
    return s ? neg(x) : x;
  endfunction
  // One shift-add step: acc is {partial_product, remaining_multiplier}, w bits each
  function automatic wide_t mul_step(input wide_t acc, input wide_t mc, input int w);
    logic [2*MAXW:0] t;
    t = {1'b0, acc};
    if (acc[0]) t = t + ({1'b0, mc} << w);
    return t[2*MAXW:1];
  endfunction
  // One restoring step: acc is {remainder, quotient}; subtract only when it fits
  function automatic wide_t div_step(input wide_t acc, input wide_t dv, input int w);
    logic [2*MAXW:0] t;
    logic [2*MAXW:0] d;
    t = {acc, 1'b0};
    d = {1'b0, dv} << w;
    if (t >= d) begin
      t = t - d;
      t[0] = 1'b1;
    end
    return t[2*MAXW-1:0];
  endfunction
endpackage

// File: rtl/mips_hilo_muldiv.sv
// mips_hilo_muldiv: iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, one bit per cycle
// Results land WIDTH+1 cycles after start; busy stalls MFHI/MFLO and further issue
module mips_hilo_muldiv
  import mips_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_enable,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  muldiv_state_t      r_state, w_next;
  muldiv_op_t         r_op;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd, r_hi, r_lo, w_res_hi, w_res_lo;
  logic               r_sa, r_sb, r_div0, r_done, w_sa, w_sb, w_unused;
  wide_t              w_a_ext, w_b_ext, w_acc_ext, w_opnd_ext, w_q_ext, w_r_ext;
  wide_t              w_ma_ext, w_mb_ext, w_st_ext, w_pr_ext, w_nq_ext, w_nr_ext;
  always_comb begin
    w_a_ext = '0;
    w_a_ext[WIDTH-1:0] = rs_val;
    w_b_ext = '0;
    w_b_ext[WIDTH-1:0] = rt_val;
    w_acc_ext = '0;
    w_acc_ext[2*WIDTH-1:0] = r_acc;
    w_opnd_ext = '0;
    w_opnd_ext[WIDTH-1:0] = r_opnd;
    w_q_ext = '0;
    w_q_ext[WIDTH-1:0] = r_acc[WIDTH-1:0];
    w_r_ext = '0;
    w_r_ext[WIDTH-1:0] = r_acc[2*WIDTH-1:WIDTH];
    w_sa = ~op[0] & rs_val[WIDTH-1];
    w_sb = ~op[0] & rt_val[WIDTH-1];
    w_ma_ext = mag(w_a_ext, w_sa);
    w_mb_ext = mag(w_b_ext, w_sb);
    w_st_ext = r_op[1] ? div_step(w_acc_ext, w_opnd_ext, WIDTH) : mul_step(w_acc_ext, w_opnd_ext, WIDTH);
    w_pr_ext = mag(w_acc_ext, r_sa ^ r_sb);
    w_nq_ext = mag(w_q_ext, r_sa ^ r_sb);
    w_nr_ext = mag(w_r_ext, r_sa);
    w_res_hi = r_op[1] ? w_nr_ext[WIDTH-1:0] : w_pr_ext[2*WIDTH-1:WIDTH];
    w_res_lo = !r_op[1] ? w_pr_ext[WIDTH-1:0] : r_div0 ? '1 : w_nq_ext[WIDTH-1:0];
    w_next = (r_state == IDLE) ? (start ? RUN : IDLE) :
             (r_state == RUN) ? ((r_cnt == '0) ? SIGN : RUN) : IDLE;
  end
  assign w_unused = ^{w_ma_ext, w_mb_ext, w_st_ext, w_pr_ext, w_nq_ext, w_nr_ext, r_op};
  always_ff @(posedge clk)
    if (reset) r_state <= IDLE;
    else if (clk_enable) r_state <= w_next;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op   <= MULT;
      r_cnt  <= '0;
      r_acc  <= '0;
      r_opnd <= '0;
      r_sa   <= 1'b0;
      r_sb   <= 1'b0;
      r_div0 <= 1'b0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
    end else if (clk_enable) begin
      r_done <= (r_state == SIGN);
      if (r_state == IDLE && start) begin
        r_op   <= muldiv_op_t'(op);
        r_sa   <= w_sa;
        r_sb   <= w_sb;
        r_div0 <= op[1] && (rt_val == '0);
        r_cnt  <= CW'(WIDTH - 1);
        r_acc  <= {{WIDTH{1'b0}}, w_ma_ext[WIDTH-1:0]};
        r_opnd <= w_mb_ext[WIDTH-1:0];
      end else if (r_state == IDLE) begin
        if (hi_we) r_hi <= wdata;
        if (lo_we) r_lo <= wdata;
      end else if (r_state == RUN) begin
        r_acc <= w_st_ext[2*WIDTH-1:0];
        r_cnt <= r_cnt - CW'(1);
      end else begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end
    end
  end
  assign busy = (r_state != IDLE);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;
endmodule

// File: tb/tb_mips_hilo_muldiv.sv
// tb_mips_hilo_muldiv: directed vectors with hand-computed HI/LO results and latencies
module tb_mips_hilo_muldiv;
  logic        clk = 1'b0;
  logic        reset, clk_enable, start, hi_we, lo_we, busy, done, seen;
  logic [1:0]  op;
  logic [31:0] rs_val, rt_val, wdata, hi, lo, m_hi, m_lo;
  int          nvec = 0;
  int          nerr = 0;
  always #5 clk = ~clk;
  mips_hilo_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  // mode: 0 plain, 1 MTHI/MTLO during RUN, 2 second start during RUN,
  //       3 clk_enable low for 5 cycles, 4 strobes alongside start
  task automatic run(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] ehi, input logic [31:0] elo, input int elat, input int mode, input bit b2b);
    int n;
    if (!b2b) @(negedge clk);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    if (mode == 4) begin hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hbad0bad0; end
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    n = 0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    while (!done && n < 200) begin
      if (mode == 1) begin hi_we = (n >= 2 && n < 6); lo_we = hi_we; wdata = 32'hdeadbeef; end
      if (mode == 2 && n == 5) begin start = 1'b1; op = 2'd3; rs_val = 32'd9; rt_val = 32'd3; end
      if (mode == 2 && n == 6) start = 1'b0;
      if (mode == 3 && n == 5) clk_enable = 1'b0;
      if (mode == 3 && n == 10) clk_enable = 1'b1;
      if (n == 20) begin
        chk({tag, "_hold_hi"}, hi, m_hi);
        chk({tag, "_hold_lo"}, lo, m_lo);
      end
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, n, elat);
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    chk({tag, "_hi"}, hi, ehi);
    chk({tag, "_lo"}, lo, elo);
    m_hi = ehi;
    m_lo = elo;
  endtask
  initial begin
    reset = 1'b1; clk_enable = 1'b1; start = 1'b0; op = 2'd0;
    rs_val = '0; rt_val = '0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    m_hi = '0; m_lo = '0; seen = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    reset = 1'b0;
    run("multu_max", 2'd1, 32'hffffffff, 32'hffffffff, 32'hfffffffe, 32'h00000001, 33, 0, 1'b0);
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd0);
    run("mult_neg", 2'd0, 32'hfffffffd, 32'd5, 32'hffffffff, 32'hfffffff1, 33, 0, 1'b0);
    run("mult_minmin", 2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 33, 0, 1'b0);
    run("div_neg", 2'd2, 32'hfffffff9, 32'd2, 32'hffffffff, 32'hfffffffd, 33, 0, 1'b0);
    run("div_ovf", 2'd2, 32'h80000000, 32'hffffffff, 32'h00000000, 32'h80000000, 33, 0, 1'b0);
    run("divu_zero", 2'd3, 32'd7, 32'd0, 32'h00000007, 32'hffffffff, 33, 0, 1'b0);
    run("div_zero_neg", 2'd2, 32'hfffffff9, 32'd0, 32'hfffffff9, 32'hffffffff, 33, 0, 1'b0);
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'h12345678;
    @(negedge clk);
    hi_we = 1'b0;
    chk("mthi_hi", hi, 32'h12345678);
    chk("mthi_lo", lo, m_lo);
    lo_we = 1'b1; wdata = 32'h9abcdef0;
    @(negedge clk);
    lo_we = 1'b0;
    chk("mtlo_lo", lo, 32'h9abcdef0);
    chk("mtlo_hi", hi, 32'h12345678);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h55aa33cc;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    chk("mtboth_hi", hi, 32'h55aa33cc);
    chk("mtboth_lo", lo, 32'h55aa33cc);
    m_hi = 32'h55aa33cc; m_lo = 32'h55aa33cc;
    run("we_in_run", 2'd1, 32'd6, 32'd7, 32'h00000000, 32'h0000002a, 33, 1, 1'b0);
    run("we_with_start", 2'd1, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 33, 4, 1'b0);
    run("start_in_run", 2'd0, 32'd100, 32'hfffffffe, 32'hffffffff, 32'hffffff38, 33, 2, 1'b0);
    run("b2b", 2'd3, 32'd100, 32'd7, 32'h00000002, 32'h0000000e, 33, 0, 1'b1);
    run("clk_en_stall", 2'd3, 32'd1003, 32'd10, 32'h00000003, 32'h00000064, 38, 3, 1'b0);
    @(negedge clk);
    start = 1'b1; op = 2'd3; rs_val = 32'd500; rt_val = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("abort_no_done", 32'(seen), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
